// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: turns an instruction's Opcode/Funct fields into the control
// bundle for the 16-bit ALU (AluCtrl result-mux select, BInvert, CarryIn),
// flags illegal encodings and counts them. A 2-entry output buffer absorbs
// ALU-side stalls.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Flush                 synchronous buffer clear (branch/exception)
//   InValid/InReady       instruction-side handshake
//   Opcode[3:0], Funct[2:0]  instruction fields
//   OutValid/OutReady     ALU-side handshake
//   AluCtrl[2:0], BInvert, CarryIn, Illegal  head-entry fields (0 when empty)
//   IllegalCount[CNT_W-1:0]  saturating count of accepted illegal encodings
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready. InReady depends only on Reset and
// the registered occupancy, never on OutReady. Output fields are held stable
// while OutValid=1 and OutReady=0.
module alu_ctrl_issue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Opcode,
  input  logic [2:0]       Funct,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [2:0]       AluCtrl,
  output logic             BInvert,
  output logic             CarryIn,
  output logic             Illegal,
  output logic [CNT_W-1:0] IllegalCount
);

  // Buffer occupancy is the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, nextState;

  // Entry layout: {Illegal, BInvert, CarryIn, AluCtrl[2:0]}
  logic [5:0] headEntry, tailEntry, decEntry;
  logic [2:0] decCtrl;
  logic       decSub;
  logic       decIll;

  logic push, pop;
  logic loadHead, loadTail, headFromTail;

  // Decode. Illegal encodings fall through with the defaults: ADD select,
  // no inversion, no carry.
  always_comb begin
    decCtrl = 3'b100;
    decSub  = 1'b0;
    decIll  = 1'b0;
    case (Opcode)
      4'b0000: begin
        case (Funct)
          3'b000: decCtrl = 3'b100;                   // ADD
          3'b001: begin decCtrl = 3'b100; decSub = 1'b1; end  // SUB
          3'b010: decCtrl = 3'b000;                   // AND
          3'b011: decCtrl = 3'b010;                   // OR
          3'b100: decCtrl = 3'b011;                   // XOR
          3'b101: begin decCtrl = 3'b110; decSub = 1'b1; end  // SLT
          default: decIll = 1'b1;
        endcase
      end
      4'b0100: decCtrl = 3'b100;                      // ADDI
      4'b0101: begin decCtrl = 3'b100; decSub = 1'b1; end     // SUBI
      4'b0110: decCtrl = 3'b000;                      // ANDI
      4'b0111: decCtrl = 3'b010;                      // ORI
      4'b1000: begin decCtrl = 3'b001; decSub = 1'b1; end     // SLTI
      4'b1001: decCtrl = 3'b011;                      // XORI
      4'b1010: begin decCtrl = 3'b100; decSub = 1'b1; end     // BEQ
      4'b1011: decCtrl = 3'b100;                      // LW
      4'b1100: decCtrl = 3'b100;                      // SW
      default: decIll = 1'b1;
    endcase
    decEntry = {decIll, decSub, decSub, decCtrl};
  end

  assign InReady  = !Reset && ({30'd0, state} < DEPTH);
  assign OutValid = (state != EMPTY);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  // Next-state and buffer steering.
  always_comb begin
    nextState    = state;
    loadHead     = 1'b0;
    loadTail     = 1'b0;
    headFromTail = 1'b0;
    if (Flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            nextState = ONE;
            loadHead  = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Old head leaves, new entry takes its place.
            loadHead = 1'b1;
          end else if (push) begin
            nextState = FULL;
            loadTail  = 1'b1;
          end else if (pop) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          // push is impossible here because InReady is low.
          if (pop) begin
            nextState    = ONE;
            headFromTail = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= EMPTY;
    else       state <= nextState;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      headEntry <= '0;
      tailEntry <= '0;
    end else begin
      if (loadHead)          headEntry <= decEntry;
      else if (headFromTail) headEntry <= tailEntry;
      if (loadTail)          tailEntry <= decEntry;
    end
  end

  // Counter survives Flush; a flushed push never counts.
  always_ff @(posedge Clock) begin
    if (Reset)
      IllegalCount <= '0;
    else if (push && decIll && !Flush && (IllegalCount != {CNT_W{1'b1}}))
      IllegalCount <= IllegalCount + 1'b1;
  end

  // Stale buffer contents are masked to zero while empty.
  assign {Illegal, BInvert, CarryIn, AluCtrl} = OutValid ? headEntry : 6'd0;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Testbench for alu_ctrl_issue: directed sequences, a full decode sweep
// table and a random phase, checked against an expected-entry queue.
module tb_alu_ctrl_issue;

  localparam int CNT_W = 8;

  logic             Clock = 1'b0;
  logic             Reset, Flush, InValid, OutReady;
  logic             InReady, OutValid, BInvert, CarryIn, Illegal;
  logic [3:0]       Opcode;
  logic [2:0]       Funct;
  logic [2:0]       AluCtrl;
  logic [CNT_W-1:0] IllegalCount;

  alu_ctrl_issue #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Funct(Funct),
    .OutValid(OutValid), .OutReady(OutReady),
    .AluCtrl(AluCtrl), .BInvert(BInvert), .CarryIn(CarryIn),
    .Illegal(Illegal), .IllegalCount(IllegalCount)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- reference / table ----------------
  typedef struct {
    logic [3:0] op;
    logic [2:0] fn;
    logic [2:0] ctrl;
    logic       bc;
    logic       ill;
  } vec_t;

  vec_t vecs[128];

  // Returns {Illegal, BInvert, CarryIn, AluCtrl}
  function automatic logic [5:0] refDecode(input logic [3:0] op, input logic [2:0] fn);
    logic [2:0] c;
    logic       s;
    logic       il;
    c = 3'b100; s = 1'b0; il = 1'b0;
    if (op == 4'd0) begin
      if      (fn == 3'd0) c = 3'b100;
      else if (fn == 3'd1) begin c = 3'b100; s = 1'b1; end
      else if (fn == 3'd2) c = 3'b000;
      else if (fn == 3'd3) c = 3'b010;
      else if (fn == 3'd4) c = 3'b011;
      else if (fn == 3'd5) begin c = 3'b110; s = 1'b1; end
      else il = 1'b1;
    end else if (op == 4'd4)  c = 3'b100;
    else if (op == 4'd5)  begin c = 3'b100; s = 1'b1; end
    else if (op == 4'd6)  c = 3'b000;
    else if (op == 4'd7)  c = 3'b010;
    else if (op == 4'd8)  begin c = 3'b001; s = 1'b1; end
    else if (op == 4'd9)  c = 3'b011;
    else if (op == 4'd10) begin c = 3'b100; s = 1'b1; end
    else if (op == 4'd11 || op == 4'd12) c = 3'b100;
    else il = 1'b1;
    return {il, s, s, c};
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  logic [5:0] curExp;
  logic [5:0] expHead;
  int         modelCnt  = 0;
  int         total     = 0;
  int         bad       = 0;
  int         forbidden = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model to
  // match the coming rising edge, then return 1 time unit after it.
  task automatic tick();
    logic accept;
    @(negedge Clock);
    check("InReady", InReady, (!Reset && exp_q.size() < 2));
    check("OutValid", OutValid, (exp_q.size() != 0));
    expHead = (exp_q.size() != 0) ? exp_q[0] : 6'd0;
    check("head", {Illegal, BInvert, CarryIn, AluCtrl}, expHead);
    check("IllegalCount", IllegalCount, modelCnt);
    if (OutValid && (AluCtrl == 3'b101 || AluCtrl == 3'b111)) forbidden++;
    if (Reset) begin
      exp_q.delete();
      modelCnt = 0;
    end else if (Flush) begin
      exp_q.delete();
    end else begin
      accept = InValid && (exp_q.size() < 2);
      if (exp_q.size() != 0 && OutReady) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back(curExp);
        if (curExp[5] && modelCnt != 255) modelCnt++;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic driveExp(input logic [3:0] op, input logic [2:0] fn, input logic v,
                          input logic ordy, input logic fl, input logic rst,
                          input logic [5:0] e);
    Opcode   = op;
    Funct    = fn;
    InValid  = v;
    OutReady = ordy;
    Flush    = fl;
    Reset    = rst;
    curExp   = e;
    tick();
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] fn, input logic v,
                       input logic ordy, input logic fl, input logic rst);
    driveExp(op, fn, v, ordy, fl, rst, refDecode(op, fn));
  endtask

  task automatic idle(input logic ordy);
    drive(4'd0, 3'd0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 128; i++) begin
      logic [5:0] e;
      vecs[i].op   = 4'(i >> 3);
      vecs[i].fn   = 3'(i);
      e            = refDecode(vecs[i].op, vecs[i].fn);
      vecs[i].ctrl = e[2:0];
      vecs[i].bc   = e[3];
      vecs[i].ill  = e[5];
    end

    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Opcode = '0; Funct = '0; curExp = '0;
    drive(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_outvalid", OutValid, 0);
    check("reset_inready", InReady, 0);

    // SUB with OutReady=1: one-cycle latency, popped next cycle.
    drive(4'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sub_valid", OutValid, 1);
    check("sub_fields", {Illegal, BInvert, CarryIn, AluCtrl}, 6'b011100);
    idle(1'b1);
    check("sub_gone", OutValid, 0);

    // SLTI then SLT with a stalled ALU; order preserved.
    drive(4'd8, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_inready", InReady, 0);
    check("slti_head", {BInvert, CarryIn, AluCtrl}, 5'b11001);
    idle(1'b1);
    check("slt_head", AluCtrl, 3'b110);

    // Full, pop and push together: only the pop happens.
    drive(4'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full2_inready", InReady, 0);
    drive(4'd6, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("popOnly_inready", InReady, 1);
    check("popOnly_head", AluCtrl, 3'b100);
    idle(1'b1);
    idle(1'b1);

    // Illegal encodings.
    drive(4'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ill1_head", {Illegal, BInvert, CarryIn, AluCtrl}, 6'b100100);
    drive(4'd15, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("ill_count3", IllegalCount, 3);

    // Flush with a full buffer and with one entry (same-cycle push dropped).
    drive(4'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'd2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_outvalid", OutValid, 0);
    check("flush_cnt", IllegalCount, 3);
    check("flush_inready", InReady, 1);
    drive(4'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'd2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush1_outvalid", OutValid, 0);
    check("flush1_cnt", IllegalCount, 3);

    // Reset with one entry pending.
    drive(4'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_inready", InReady, 0);
    check("rst_outs", {OutValid, Illegal, BInvert, CarryIn, AluCtrl}, 0);
    check("rst_cnt", IllegalCount, 0);
    idle(1'b0);
    check("rst_release_inready", InReady, 1);

    // Decode sweep from the table.
    for (int i = 0; i < 128; i++)
      driveExp(vecs[i].op, vecs[i].fn, 1'b1, 1'b1, 1'b0, 1'b0,
               {vecs[i].ill, vecs[i].bc, vecs[i].bc, vecs[i].ctrl});
    idle(1'b1);
    idle(1'b1);

    // Saturation of the illegal counter.
    for (int i = 0; i < 260; i++) drive(4'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("sat_cnt", IllegalCount, 255);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0));
    for (int i = 0; i < 4; i++) idle(1'b1);

    check("forbidden_ctrl", forbidden, 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
